biphasic_sched: RTL and testbench
=================================

Name: biphasic_sched

Overview:
Round-robin scheduler that time-shares one biphasic pulse engine across NCH electrode channels.
- Grants the engine to one requesting channel at a time for a slot of PULSES_PER_SLOT charge-balanced pulses.
- Routes the engine's positive, negative and shorted phase strobes to the granted channel only.
- Enforces a guard interval between slots.
- Sits between the per-channel request logic and the single pulse engine instance.

Parameters:
- NCH, 4: number of electrode channels (2..16).
- CH_W, $clog2(NCH): channel index width.
- PULSES_PER_SLOT, 8: completed pulses per grant (>=1).
- CNT_W, 16: width of the pulse and guard counters.
- GUARD, 100: idle cycles between the end of one slot and the next arbitration (>=1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sched_en  in  1  global scheduler enable
- req  in  NCH  per-channel stimulation request (level)
- eng_pos  in  1  engine positive-phase strobe
- eng_neg  in  1  engine negative-phase strobe
- eng_enable  out  1  engine enable (registered)
- ch_sel  out  CH_W  index of the granted channel
- grant  out  NCH  one-hot grant; all zero when no slot is active
- out_pos  out  NCH  per-channel positive strobe
- out_neg  out  NCH  per-channel negative strobe
- out_short  out  NCH  per-channel short/discharge
- slot_done  out  NCH  one-cycle pulse when a channel's slot ends
- slot_abort  out  1  valid with slot_done; 1 = slot ended early

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). All state changes occur on the posedge of clk.
- Reset values:
  - state=IDLE, eng_enable=0, grant=0, ch_sel=0.
  - rr_ptr=0, pulse_cnt=0, guard_cnt=0, in_pulse=0.
  - slot_done=0, slot_abort=0.
  - out_pos=0, out_neg=0, out_short=all ones.
- Routing is combinational from the registered grant:
  - out_pos[i] = eng_pos & grant[i]
  - out_neg[i] = eng_neg & grant[i]
  - out_short[i] = ~out_pos[i] & ~out_neg[i]
- Edge tracking:
  - eng_neg is registered as neg_q; a pulse completes when neg_q=1 and eng_neg=0.
  - in_pulse is set when eng_pos=1 and cleared on pulse completion.
- FSM states: IDLE, ARB, RUN, DRAIN, GUARD.
  - IDLE: go to ARB when sched_en=1 and |req.
  - ARB (1 cycle):
    - Pick the first i with req[i]=1, scanning from rr_ptr upward with wrap modulo NCH.
    - Load grant, ch_sel=i, rr_ptr=(i+1) mod NCH, pulse_cnt=0; set eng_enable=1; go to RUN.
    - If no request remains, go to IDLE.
  - RUN:
    - pulse_cnt increments on each pulse completion.
    - When the increment reaches PULSES_PER_SLOT, clear eng_enable on the next edge and go to DRAIN with abort=0.
    - If req[ch_sel]=0 or sched_en=0, clear eng_enable and go to DRAIN with abort=1.
    - Completion on the same cycle as a request drop counts as normal (abort=0).
  - DRAIN:
    - Hold grant; wait until in_pulse=0 and eng_pos=0, then go to GUARD.
    - Any in-flight pulse finishes its negative phase on the granted channel, preserving charge balance.
    - On exit, pulse slot_done[ch_sel]=1 and slot_abort for one cycle; clear grant; guard_cnt=0.
  - GUARD: increment guard_cnt; when guard_cnt==GUARD-1, go to ARB (next arbitration).
- Engine constraint: the engine's inter-pulse gap must be >=2 cycles, so the registered eng_enable drop is seen before the next positive phase.
- sched_en=0 in IDLE, ARB or GUARD: go to IDLE at the next edge; no slot_done.
- Pulse activity outside RUN/DRAIN is ignored. Nothing is routed because grant=0.
- Synchronous reset mid-slot forces reset values immediately; the engine must share the same reset.
- Counters saturate at their maximum value; they never wrap.

Decomposition:
- Shared package stim_pkg holds:
  - the state encoding (IDLE..GUARD);
  - the default slot and guard constants;
  - the phase-strobe struct (pos, neg).
- Sub-module rr_pick: combinational NCH-wide round-robin priority picker. Inputs are req and rr_ptr; outputs are found and index.

Test Plan:
- Single channel: req=0100, PULSES_PER_SLOT=8 → eng_enable for exactly 8 pulses; out_pos/out_neg only on channel 2; slot_done[2] with abort=0; next ARB exactly 100 cycles later.
- All channels requesting (req=1111): grants in order 0,1,2,3,0, each separated by a 100-cycle guard; grant stays one-hot throughout; out_short=1 on all non-granted channels.
- Abort mid-pulse: drop req[1] during eng_pos of pulse 3 → eng_enable falls next cycle; negative phase still routed to channel 1; slot_done[1] with abort=1 after eng_neg falls.
- Simultaneous events: 8th completion on the same cycle as req drop → abort=0, pulse_cnt=8. sched_en drop during GUARD → IDLE, no grant.
- Reset in RUN: reset=1 for one cycle → next cycle eng_enable=0, grant=0, out_short=1111, rr_ptr=0.
- Wrap: rr_ptr=3 with req=1001 → grant channel 3, then channel 0.

Source files
------------

// File: rtl/stim_pkg.sv
// Shared types and defaults for the biphasic stimulation scheduler.
// State encoding, slot/guard defaults and the engine phase-strobe bundle.
package stim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_RUN,
    ST_DRAIN,
    ST_GUARD
  } state_t;

  localparam int DEF_PULSES_PER_SLOT = 8;
  localparam int DEF_GUARD           = 100;

  typedef struct packed {
    logic pos;
    logic neg;
  } phase_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker: first set request at or after rr_ptr,
// wrapping modulo NCH.
module rr_pick #(
  parameter int NCH  = 4,
  parameter int CH_W = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [CH_W-1:0] rr_ptr,
  output logic            found,
  output logic [CH_W-1:0] index
);

  int j;

  // Scan from the far end so the closest candidate is written last.
  always_comb begin
    found = 1'b0;
    index = '0;
    j     = 0;
    for (int k = NCH - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= NCH) j = j - NCH;
      if (req[j]) begin
        found = 1'b1;
        index = CH_W'(j);
      end
    end
  end

endmodule

// File: rtl/biphasic_sched.sv
// Round-robin scheduler time-sharing one biphasic pulse engine
// across NCH electrode channels, with per-slot pulse budget and guard.
module biphasic_sched
  import stim_pkg::*;
#(
  parameter int NCH             = 4,
  parameter int CH_W            = $clog2(NCH),
  parameter int PULSES_PER_SLOT = DEF_PULSES_PER_SLOT,
  parameter int CNT_W           = 16,
  parameter int GUARD           = DEF_GUARD
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sched_en,
  input  logic [NCH-1:0]  req,
  input  logic            eng_pos,
  input  logic            eng_neg,
  output logic            eng_enable,
  output logic [CH_W-1:0] ch_sel,
  output logic [NCH-1:0]  grant,
  output logic [NCH-1:0]  out_pos,
  output logic [NCH-1:0]  out_neg,
  output logic [NCH-1:0]  out_short,
  output logic [NCH-1:0]  slot_done,
  output logic            slot_abort
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] PPS     = CNT_W'(PULSES_PER_SLOT);
  localparam logic [CNT_W-1:0] G_LAST  = CNT_W'(GUARD - 1);

  phase_t eng;
  assign eng.pos = eng_pos;
  assign eng.neg = eng_neg;

  state_t           state_q, state_d;
  logic [NCH-1:0]   grant_q, grant_d;
  logic [CH_W-1:0]  ch_sel_q, ch_sel_d;
  logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [CNT_W-1:0] guard_cnt_q, guard_cnt_d;
  logic             in_pulse_q, in_pulse_d;
  logic             neg_q;
  logic             eng_en_q, eng_en_d;
  logic [NCH-1:0]   done_q, done_d;
  logic             abort_q, abort_d;
  logic             pend_q, pend_d;

  logic             found;
  logic [CH_W-1:0]  pick;
  logic             pulse_end;
  logic [CNT_W-1:0] pulse_inc;

  rr_pick #(
    .NCH  (NCH),
    .CH_W (CH_W)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .found  (found),
    .index  (pick)
  );

  assign pulse_end = neg_q & ~eng.neg;
  assign pulse_inc = (pulse_cnt_q == CNT_MAX) ? pulse_cnt_q
                                              : pulse_cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ch_sel_d    = ch_sel_q;
    rr_ptr_d    = rr_ptr_q;
    pulse_cnt_d = pulse_cnt_q;
    guard_cnt_d = guard_cnt_q;
    eng_en_d    = eng_en_q;
    pend_d      = pend_q;
    done_d      = '0;
    abort_d     = 1'b0;
    in_pulse_d  = in_pulse_q;
    if (eng.pos)        in_pulse_d = 1'b1;
    else if (pulse_end) in_pulse_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (sched_en && |req) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (!sched_en || !found) begin
          state_d = ST_IDLE;
        end else begin
          grant_d     = NCH'(1) << pick;
          ch_sel_d    = pick;
          rr_ptr_d    = (pick == CH_W'(NCH - 1)) ? '0 : pick + 1'b1;
          pulse_cnt_d = '0;
          eng_en_d    = 1'b1;
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        if (pulse_end) pulse_cnt_d = pulse_inc;
        // A final completion wins over a same-cycle request drop.
        if (pulse_end && pulse_inc >= PPS) begin
          eng_en_d = 1'b0;
          pend_d   = 1'b0;
          state_d  = ST_DRAIN;
        end else if (!req[ch_sel_q] || !sched_en) begin
          eng_en_d = 1'b0;
          pend_d   = 1'b1;
          state_d  = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!in_pulse_q && !eng.pos) begin
          done_d[ch_sel_q] = 1'b1;
          abort_d          = pend_q;
          grant_d          = '0;
          guard_cnt_d      = '0;
          state_d          = ST_GUARD;
        end
      end
      ST_GUARD: begin
        if (!sched_en) begin
          state_d = ST_IDLE;
        end else if (guard_cnt_q == G_LAST) begin
          state_d = ST_ARB;
        end else if (guard_cnt_q != CNT_MAX) begin
          guard_cnt_d = guard_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      ch_sel_q    <= '0;
      rr_ptr_q    <= '0;
      pulse_cnt_q <= '0;
      guard_cnt_q <= '0;
      in_pulse_q  <= 1'b0;
      neg_q       <= 1'b0;
      eng_en_q    <= 1'b0;
      done_q      <= '0;
      abort_q     <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ch_sel_q    <= ch_sel_d;
      rr_ptr_q    <= rr_ptr_d;
      pulse_cnt_q <= pulse_cnt_d;
      guard_cnt_q <= guard_cnt_d;
      in_pulse_q  <= in_pulse_d;
      neg_q       <= eng.neg;
      eng_en_q    <= eng_en_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      pend_q      <= pend_d;
    end
  end

  assign eng_enable = eng_en_q;
  assign ch_sel     = ch_sel_q;
  assign grant      = grant_q;
  assign slot_done  = done_q;
  assign slot_abort = abort_q;
  assign out_pos    = {NCH{eng.pos}} & grant_q;
  assign out_neg    = {NCH{eng.neg}} & grant_q;
  assign out_short  = ~(out_pos | out_neg);

endmodule

// File: tb/tb_biphasic_sched.sv
// Directed bench for biphasic_sched with a hand-driven pulse engine.
// Checks grant order, routing, slot budget, guard timing, abort and reset.
module tb_biphasic_sched;
  import stim_pkg::*;

  logic       clk = 1'b0;
  logic       reset, sched_en, eng_pos, eng_neg;
  logic [3:0] req;
  logic       eng_enable, slot_abort;
  logic [1:0] ch_sel;
  logic [3:0] grant, out_pos, out_neg, out_short, slot_done;

  biphasic_sched dut (
    .clk        (clk),
    .reset      (reset),
    .sched_en   (sched_en),
    .req        (req),
    .eng_pos    (eng_pos),
    .eng_neg    (eng_neg),
    .eng_enable (eng_enable),
    .ch_sel     (ch_sel),
    .grant      (grant),
    .out_pos    (out_pos),
    .out_neg    (out_neg),
    .out_short  (out_short),
    .slot_done  (slot_done),
    .slot_abort (slot_abort)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         done_cnt = 0, last_done_cyc = 0;
  int         grant_cnt = 0, last_grant_cyc = 0;
  int         onehot_viol = 0, short_viol = 0;
  logic [3:0] last_done_vec = '0, last_grant_vec = '0, prev_grant = '0;
  logic       last_abort = 1'b0;

  always @(negedge clk) begin
    prev_grant <= grant;
    if (slot_done != 4'b0) begin
      done_cnt      <= done_cnt + 1;
      last_done_vec <= slot_done;
      last_abort    <= slot_abort;
      last_done_cyc <= cyc;
    end
    if (prev_grant == 4'b0 && grant != 4'b0) begin
      grant_cnt      <= grant_cnt + 1;
      last_grant_vec <= grant;
      last_grant_cyc <= cyc;
    end
    if ($countones(grant) > 1) onehot_viol <= onehot_viol + 1;
    if ((out_short | grant) != 4'hF) short_viol <= short_viol + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; sched_en = 1'b0; req = '0;
    eng_pos = 1'b0; eng_neg = 1'b0;
    step(); step();
    reset = 1'b0;
    #1;
  endtask

  task automatic pulse(input logic [3:0] g);
    eng_pos = 1'b1;
    #1;
    checks++;
    if (out_pos !== g || out_neg !== 4'b0) begin
      failures++;
      $display("FAIL route_pos got pos=%b neg=%b exp pos=%b", out_pos, out_neg, g);
    end
    step(); step();
    eng_pos = 1'b0; eng_neg = 1'b1;
    #1;
    checks++;
    if (out_neg !== g || out_pos !== 4'b0) begin
      failures++;
      $display("FAIL route_neg got neg=%b pos=%b exp neg=%b", out_neg, out_pos, g);
    end
    step(); step();
    eng_neg = 1'b0;
    step(); step();
  endtask

  task automatic wait_enable(output bit ok);
    for (int i = 0; i < 300; i++) begin
      if (eng_enable) break;
      step();
    end
    ok = eng_enable;
  endtask

  task automatic run_slot(input int ch, output int np);
    bit ok;
    logic [3:0] g;
    g = 4'(1 << ch);
    np = 0;
    wait_enable(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL slot_start ch=%0d got enable=0 exp enable=1", ch);
    end else begin
      checks++;
      if (grant !== g) begin
        failures++;
        $display("FAIL slot_grant got=%b exp=%b", grant, g);
      end
      checks++;
      if (ch_sel !== 2'(ch)) begin
        failures++;
        $display("FAIL slot_ch_sel got=%0d exp=%0d", ch_sel, ch);
      end
      while (eng_enable && np < 20) begin
        pulse(g);
        np++;
      end
    end
    step(); step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (eng_enable !== 1'b0 || grant !== 4'b0 || ch_sel !== 2'b0) begin
      failures++;
      $display("FAIL reset_ctrl got en=%b grant=%b ch=%0d exp 0/0000/0", eng_enable, grant, ch_sel);
    end
    checks++;
    if (slot_done !== 4'b0 || slot_abort !== 1'b0) begin
      failures++;
      $display("FAIL reset_done got done=%b abort=%b exp 0000/0", slot_done, slot_abort);
    end
    checks++;
    if (out_pos !== 4'b0 || out_neg !== 4'b0 || out_short !== 4'hF) begin
      failures++;
      $display("FAIL reset_route got pos=%b neg=%b short=%b exp 0000/0000/1111", out_pos, out_neg, out_short);
    end
  endtask

  task automatic test_single();
    int np, d0, g0;
    do_reset();
    d0 = done_cnt; g0 = grant_cnt;
    req = 4'b0100; sched_en = 1'b1;
    run_slot(2, np);
    checks++;
    if (np !== 8) begin
      failures++;
      $display("FAIL single_pulses got=%0d exp=8", np);
    end
    checks++;
    if (done_cnt !== d0 + 1 || last_done_vec !== 4'b0100 || last_abort !== 1'b0) begin
      failures++;
      $display("FAIL single_done got n=%0d vec=%b abort=%b exp n=%0d vec=0100 abort=0", done_cnt - d0, last_done_vec, last_abort, 1);
    end
    for (int i = 0; i < 200; i++) begin
      if (grant_cnt >= g0 + 2) break;
      step();
    end
    checks++;
    if (grant_cnt !== g0 + 2 || last_grant_cyc - last_done_cyc !== 101 || last_grant_vec !== 4'b0100) begin
      failures++;
      $display("FAIL single_guard got grants=%0d gap=%0d vec=%b exp 2/101/0100", grant_cnt - g0, last_grant_cyc - last_done_cyc, last_grant_vec);
    end
  endtask

  task automatic test_all();
    int np, prev_done, oh0, sh0;
    do_reset();
    oh0 = onehot_viol; sh0 = short_viol;
    prev_done = 0;
    req = 4'hF; sched_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      run_slot(k % 4, np);
      checks++;
      if (np !== 8 || last_done_vec !== 4'(1 << (k % 4))) begin
        failures++;
        $display("FAIL all_slot%0d got np=%0d vec=%b exp np=8 ch=%0d", k, np, last_done_vec, k % 4);
      end
      if (k > 0) begin
        checks++;
        if (last_grant_cyc - prev_done !== 101) begin
          failures++;
          $display("FAIL all_guard%0d got gap=%0d exp=101", k, last_grant_cyc - prev_done);
        end
      end
      prev_done = last_done_cyc;
    end
    checks++;
    if (onehot_viol !== oh0 || short_viol !== sh0) begin
      failures++;
      $display("FAIL all_onehot_short got oh=%0d sh=%0d exp 0/0", onehot_viol - oh0, short_viol - sh0);
    end
  endtask

  task automatic test_abort();
    bit ok;
    int d0, nf;
    do_reset();
    d0 = done_cnt;
    req = 4'b0010; sched_en = 1'b1;
    wait_enable(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL abort_start got enable=0 exp enable=1");
    end
    pulse(4'b0010);
    pulse(4'b0010);
    eng_pos = 1'b1;
    step();
    req = 4'b0000;
    step();
    checks++;
    if (eng_enable !== 1'b0 || grant !== 4'b0010) begin
      failures++;
      $display("FAIL abort_drop got en=%b grant=%b exp 0/0010", eng_enable, grant);
    end
    eng_pos = 1'b0; eng_neg = 1'b1;
    #1;
    checks++;
    if (out_neg !== 4'b0010) begin
      failures++;
      $display("FAIL abort_neg_route got=%b exp=0010", out_neg);
    end
    step(); step();
    checks++;
    if (done_cnt !== d0) begin
      failures++;
      $display("FAIL abort_early_done got n=%0d exp=0", done_cnt - d0);
    end
    eng_neg = 1'b0;
    nf = cyc;
    step(); step(); step();
    checks++;
    if (done_cnt !== d0 + 1 || last_done_vec !== 4'b0010 || last_abort !== 1'b1 || last_done_cyc <= nf) begin
      failures++;
      $display("FAIL abort_done got n=%0d vec=%b abort=%b at=%0d exp n=1 vec=0010 abort=1 after=%0d", done_cnt - d0, last_done_vec, last_abort, last_done_cyc, nf);
    end
  endtask

  task automatic test_simul();
    bit ok;
    int d0, g0;
    do_reset();
    d0 = done_cnt;
    req = 4'b0001; sched_en = 1'b1;
    wait_enable(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL simul_start got enable=0 exp enable=1");
    end
    for (int i = 0; i < 7; i++) pulse(4'b0001);
    eng_pos = 1'b1;
    step(); step();
    eng_pos = 1'b0; eng_neg = 1'b1;
    step(); step();
    eng_neg = 1'b0; req = 4'b0000;
    step();
    checks++;
    if (eng_enable !== 1'b0 || dut.pulse_cnt_q !== 16'd8) begin
      failures++;
      $display("FAIL simul_end got en=%b cnt=%0d exp 0/8", eng_enable, dut.pulse_cnt_q);
    end
    step(); step();
    checks++;
    if (done_cnt !== d0 + 1 || last_done_vec !== 4'b0001 || last_abort !== 1'b0) begin
      failures++;
      $display("FAIL simul_done got n=%0d vec=%b abort=%b exp 1/0001/0", done_cnt - d0, last_done_vec, last_abort);
    end
    req = 4'b0001;
    for (int i = 0; i < 10; i++) step();
    sched_en = 1'b0;
    g0 = grant_cnt; d0 = done_cnt;
    for (int i = 0; i < 150; i++) step();
    checks++;
    if (grant_cnt !== g0 || grant !== 4'b0 || done_cnt !== d0 || dut.state_q !== ST_IDLE) begin
      failures++;
      $display("FAIL guard_disable got grants=%0d grant=%b done=%0d state=%0d exp 0/0000/0/IDLE", grant_cnt - g0, grant, done_cnt - d0, dut.state_q);
    end
  endtask

  task automatic test_reset_run();
    bit ok;
    do_reset();
    req = 4'b0001; sched_en = 1'b1;
    wait_enable(ok);
    pulse(4'b0001);
    eng_pos = 1'b1;
    step();
    reset = 1'b1;
    step();
    checks++;
    if (eng_enable !== 1'b0 || grant !== 4'b0 || out_short !== 4'hF) begin
      failures++;
      $display("FAIL rst_run got en=%b grant=%b short=%b exp 0/0000/1111", eng_enable, grant, out_short);
    end
    checks++;
    if (dut.rr_ptr_q !== 2'd0 || ch_sel !== 2'd0) begin
      failures++;
      $display("FAIL rst_run_ptr got ptr=%0d ch=%0d exp 0/0", dut.rr_ptr_q, ch_sel);
    end
    reset = 1'b0; eng_pos = 1'b0;
    step();
  endtask

  task automatic test_wrap();
    int np;
    do_reset();
    req = 4'b0100; sched_en = 1'b1;
    run_slot(2, np);
    checks++;
    if (dut.rr_ptr_q !== 2'd3) begin
      failures++;
      $display("FAIL wrap_ptr got=%0d exp=3", dut.rr_ptr_q);
    end
    req = 4'b1001;
    run_slot(3, np);
    run_slot(0, np);
    checks++;
    if (last_done_vec !== 4'b0001 || np !== 8) begin
      failures++;
      $display("FAIL wrap_done got vec=%b np=%0d exp 0001/8", last_done_vec, np);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all();
    test_abort();
    test_simul();
    test_reset_run();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
